i2c_target_rx: RTL and testbench
================================

Name: i2c_target_rx

Overview:
- I2C target (slave) receive engine: the far end of the team's I2C clock generator with stretching.
- Samples the open-drain SCL/SDA lines and detects START/STOP.
- Matches a 7-bit address and shifts in write bytes, which it hands to local logic over a valid/ready port.
- ACKs each accepted byte and holds SCL low (clock stretching) when local logic has not consumed the previous byte.

Parameters:
- ADDR, 7'h50, target address matched against the first byte after START.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (min 2).
- TSU_CYCLES, 4, clk cycles SDA is held valid before SCL is released after a stretch (data setup).

Ports:
- clk  input  1  system clock, at least 8x SCL rate.
- rst  input  1  reset, synchronous, active-high.
- scl_in  input  1  raw SCL line level.
- sda_in  input  1  raw SDA line level.
- scl_oe  output  1  1 = pull SCL low (stretch); 0 = release.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  output  8  received byte, MSB first on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  local logic accepts rx_data.
- rx_first  output  1  qualifies rx_data: first byte after the address phase.
- stop_det  output  1  one-cycle pulse on STOP detected while addressed.
- busy  output  1  1 from address match until STOP, repeated START or reset.

Behaviour:
- Reset:
  - scl_oe=0, sda_oe=0, rx_valid=0, rx_first=0, stop_det=0, busy=0, rx_data=0.
  - State=IDLE; synchronizer flops and previous-sample flops preset to 1 (idle bus).
  - Reset mid-transfer releases both lines in the same cycle rst is sampled.
- Line conditioning:
  - scl_s/sda_s are the synchronizer outputs.
  - Edges are derived against one registered previous sample.
  - Event latency is SYNC_STAGES+1 clk from the pin.
- Bus conditions:
  - START: scl_s=1 and sda_s falls.
  - STOP: scl_s=1 and sda_s rises.
  - A START in any state (repeated START) clears the bit counter, clears busy, releases sda_oe and scl_oe, and enters ADDR.
  - A STOP in any state goes to IDLE and releases both lines; stop_det pulses only if busy was 1.
- Data:
  - Sampled on the scl_s rising edge.
  - sda_oe changes only on the scl_s falling edge, or at a stretch release.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits plus R/W). After the 8th rise:
    - {addr match, R/W=0} -> ADDR_ACK.
    - Otherwise -> IGNORE (no ACK, lines untouched until START/STOP).
  - ADDR_ACK:
    - On the next SCL fall, sda_oe=1 and busy=1.
    - On the following fall, sda_oe=0 and go to DATA.
    - Set an internal first flag.
  - DATA: shift 8 bits. On the SCL fall after the 8th rise:
    - If rx_valid=0: load rx_data, set rx_valid=1, copy the first flag to rx_first, clear the first flag, assert sda_oe=1, go to DATA_ACK.
    - If rx_valid=1: assert scl_oe=1 and go to STRETCH.
  - STRETCH:
    - Hold scl_oe=1.
    - When the previous byte is consumed (rx_valid & rx_ready), load the new byte and set sda_oe=1 in the next cycle.
    - Count TSU_CYCLES, release scl_oe=0, go to DATA_ACK.
  - DATA_ACK: on the SCL fall ending the 9th clock, sda_oe=0 and return to DATA.
- Handshake:
  - Transfer occurs when rx_valid & rx_ready; rx_valid drops the next cycle.
  - rx_data and rx_first are stable while rx_valid=1.
  - If a load and a consume fall in the same cycle, the load wins: rx_valid stays 1 with the new data.
- STOP or START during STRETCH:
  - Abort: release scl_oe, discard the pending byte.
  - rx_valid keeps its already-valid byte.
- Bit counter: 4 bits; it never wraps past 8 without passing through an ACK state.

Optional Feature:
- Macro I2C_TARGET_GCALL_EN.
- When defined: address byte 8'h00 (general call, R/W=0) is also ACKed and enters DATA like a match. Output gcall (1 bit) is held high from that ACK until STOP or START.
- When undefined: 8'h00 goes to IGNORE and the gcall port is absent.

Test Plan:
- Write to 0x50, bytes 0xA5 then 0x3C, rx_ready tied 1 -> address byte and each data byte ACKed (sda_oe=1 over the 9th clock); rx_data 0xA5 with rx_first=1, then 0x3C with rx_first=0; stop_det pulses once; scl_oe never asserted.
- Write to 0x51 -> no ACK, sda_oe=0 throughout, rx_valid never set, busy=0, stop_det does not pulse.
- rx_ready=0, write bytes 0x11, 0x22 -> 0x11 is ACKed; on the fall after the 8th bit of 0x22, scl_oe=1. Raise rx_ready 50 clk later -> 0x11 consumed, rx_data=0x22, sda_oe=1, scl_oe released exactly TSU_CYCLES clk after sda_oe=1.
- Read request to 0x50 (address byte 0xA1) -> NACK, state IGNORE; a following START plus write to 0x50 is ACKed normally.
- Repeated START in the middle of the 5th data bit, then a new write to 0x50 with 0x77 -> partial byte discarded; 0x77 delivered with rx_first=1.
- rst asserted while in STRETCH -> scl_oe=0, sda_oe=0, rx_valid=0, busy=0 in the cycle after rst is sampled.

Source files
------------

// File: rtl/i2c_target_rx_if.sv
// Bus and local-handshake bundle for the I2C target receive engine.
// The gcall signal exists only when I2C_TARGET_GCALL_EN is defined.
interface i2c_target_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_first;
  logic       stop_det;
  logic       busy;
`ifdef I2C_TARGET_GCALL_EN
  logic       gcall;

  modport slave (
    input  scl_in, sda_in, rx_ready,
    output scl_oe, sda_oe, rx_data, rx_valid, rx_first, stop_det, busy, gcall
  );

  modport master (
    output scl_in, sda_in, rx_ready,
    input  scl_oe, sda_oe, rx_data, rx_valid, rx_first, stop_det, busy, gcall
  );
`else
  modport slave (
    input  scl_in, sda_in, rx_ready,
    output scl_oe, sda_oe, rx_data, rx_valid, rx_first, stop_det, busy
  );

  modport master (
    output scl_in, sda_in, rx_ready,
    input  scl_oe, sda_oe, rx_data, rx_valid, rx_first, stop_det, busy
  );
`endif
endinterface

// File: rtl/i2c_target_rx.sv
// I2C target write-receive engine: START/STOP detect, 7-bit address match, byte ACK,
// clock stretching while local logic still holds the previous byte.
// Optional general-call ACK (address byte 8'h00) with gcall output: define I2C_TARGET_GCALL_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | bus idle or not addressed, waiting for START
// ST_ADDR     | shifting address byte (7 address bits + R/W)
// ST_ADDR_ACK | driving ACK for the address byte over the 9th clock
// ST_IGNORE   | not for us (or read request), lines untouched until START/STOP
// ST_DATA     | shifting a write byte
// ST_STRETCH  | byte complete but rx_data still occupied, SCL held low
// ST_DATA_ACK | driving ACK for a data byte over the 9th clock
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         TSU_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           rst,
  i2c_target_rx_if.slave bus
);

  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TSU   = (TSU_CYCLES < 1) ? 1 : TSU_CYCLES;
  localparam int TW    = $clog2(TSU + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE,
    ST_DATA,
    ST_STRETCH,
    ST_DATA_ACK
  } state_t;

  state_t state_q, state_d;

  logic [NSYNC-1:0] scl_sync, sda_sync;
  logic             scl_s, sda_s, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_c, stop_c;

  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d, shift_nx;
  logic          sda_oe_q, sda_oe_d;
  logic          scl_oe_q, scl_oe_d;
  logic          busy_q, busy_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_first_q, rx_first_d;
  logic          first_q, first_d;
  logic          stop_q, stop_d;
  logic [TW-1:0] tsu_q, tsu_d;
  logic          loaded_q, loaded_d;
`ifdef I2C_TARGET_GCALL_EN
  logic          gc_hit_q, gc_hit_d;
  logic          gcall_q, gcall_d;
`endif

  // Line conditioning: presets model an idle (pulled-up) bus so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NSYNC-2:0], bus.scl_in};
      sda_sync <= {sda_sync[NSYNC-2:0], bus.sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[NSYNC-1];
  assign sda_s    = sda_sync[NSYNC-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_c  = scl_s & sda_q & ~sda_s;
  assign stop_c   = scl_s & ~sda_q & sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      first_q    <= 1'b0;
      stop_q     <= 1'b0;
      tsu_q      <= '0;
      loaded_q   <= 1'b0;
`ifdef I2C_TARGET_GCALL_EN
      gc_hit_q   <= 1'b0;
      gcall_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      first_q    <= first_d;
      stop_q     <= stop_d;
      tsu_q      <= tsu_d;
      loaded_q   <= loaded_d;
`ifdef I2C_TARGET_GCALL_EN
      gc_hit_q   <= gc_hit_d;
      gcall_q    <= gcall_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_first_d = rx_first_q;
    first_d    = first_q;
    stop_d     = 1'b0;
    tsu_d      = tsu_q;
    loaded_d   = loaded_q;
`ifdef I2C_TARGET_GCALL_EN
    gc_hit_d   = gc_hit_q;
    gcall_d    = gcall_q;
`endif
    shift_nx   = {shreg_q[6:0], sda_s};
    // Consume by default; any load below overrides it (load wins)
    rx_valid_d = rx_valid_q & ~bus.rx_ready;

    if (start_c) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b0;
      loaded_d  = 1'b0;
`ifdef I2C_TARGET_GCALL_EN
      gc_hit_d  = 1'b0;
      gcall_d   = 1'b0;
`endif
    end else if (stop_c) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b0;
      stop_d    = busy_q;
      busy_d    = 1'b0;
      loaded_d  = 1'b0;
`ifdef I2C_TARGET_GCALL_EN
      gc_hit_d  = 1'b0;
      gcall_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_ADDR: begin
          if (scl_rise) begin
            shreg_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (shift_nx == {ADDR, 1'b0}) begin
                state_d = ST_ADDR_ACK;
              end
`ifdef I2C_TARGET_GCALL_EN
              else if (shift_nx == 8'h00) begin
                state_d  = ST_ADDR_ACK;
                gc_hit_d = 1'b1;
              end
`endif
              else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        // First fall drives ACK, second fall (end of 9th clock) releases it
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              first_d  = 1'b1;
`ifdef I2C_TARGET_GCALL_EN
              gcall_d  = gc_hit_q;
`endif
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
          end
        end

        ST_IGNORE: ;

        ST_DATA: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            shreg_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = '0;
            if (!rx_valid_q) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              sda_oe_d   = 1'b1;
              state_d    = ST_DATA_ACK;
            end else begin
              scl_oe_d = 1'b1;
              loaded_d = 1'b0;
              state_d  = ST_STRETCH;
            end
          end
        end

        // shreg holds the pending byte; the slot is free once the old byte is taken
        ST_STRETCH: begin
          if (!loaded_q) begin
            if (!rx_valid_q || bus.rx_ready) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              sda_oe_d   = 1'b1;
              loaded_d   = 1'b1;
              tsu_d      = TW'(TSU - 1);
            end
          end else if (tsu_q == '0) begin
            scl_oe_d = 1'b0;
            loaded_d = 1'b0;
            state_d  = ST_DATA_ACK;
          end else begin
            tsu_d = tsu_q - TW'(1);
          end
        end

        ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_DATA;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.scl_oe   = scl_oe_q;
  assign bus.sda_oe   = sda_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_first = rx_first_q;
  assign bus.stop_det = stop_q;
  assign bus.busy     = busy_q;
`ifdef I2C_TARGET_GCALL_EN
  assign bus.gcall    = gcall_q;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: an open-drain I2C master model drives writes,
// a posedge monitor logs handshakes and counts output activity.
module tb_i2c_target_rx;
  localparam int Q   = 5;
  localparam int TSU = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic rdy   = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  int stop_cnt = 0, sda_cyc = 0, scl_cyc = 0, rxv_cyc = 0, busy_cyc = 0, log_n = 0;
  logic [8:0] log_mem [64];

  i2c_target_rx_if bus ();

  assign bus.scl_in   = scl_m & ~bus.scl_oe;
  assign bus.sda_in   = sda_m & ~bus.sda_oe;
  assign bus.rx_ready = rdy;

  i2c_target_rx #(
    .ADDR        (7'h50),
    .SYNC_STAGES (2),
    .TSU_CYCLES  (TSU)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.stop_det) stop_cnt <= stop_cnt + 1;
    if (bus.sda_oe)   sda_cyc  <= sda_cyc + 1;
    if (bus.scl_oe)   scl_cyc  <= scl_cyc + 1;
    if (bus.rx_valid) rxv_cyc  <= rxv_cyc + 1;
    if (bus.busy)     busy_cyc <= busy_cyc + 1;
    if (!rst && bus.rx_valid && rdy) begin
      log_mem[6'(log_n)] <= {bus.rx_first, bus.rx_data};
      log_n              <= log_n + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic scl_high();
    int i;
    scl_m = 1'b1;
    #1;
    i = 0;
    while (!bus.scl_in && i < 400) begin
      tick(1);
      i++;
    end
    if (!bus.scl_in) check("scl_stretch_timeout", 32'(bus.scl_in), 32'd1);
  endtask

  task automatic send_bit(input logic b, output logic line);
    sda_m = b;
    tick(Q);
    scl_high();
    tick(Q);
    line = bus.sda_in;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    logic l;
    for (int i = 7; i > 7 - n; i--) send_bit(d[i], l);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic l;
    send_bits(d, 8);
    send_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl_high();
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_high();
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  logic       ack;
  logic [7:0] cap;
  int         base, s_stop, s_sda, s_scl, s_rxv, s_busy, t_sda, t_scl;

  initial begin
    // Reset
    tick(3);
    check("rst_ctrl", 32'({bus.scl_oe, bus.sda_oe, bus.rx_valid, bus.rx_first, bus.stop_det, bus.busy}), 32'd0);
    check("rst_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    tick(3);

    // Write 0xA5, 0x3C to 0x50 with rx_ready held high
    rdy = 1'b1;
    base = log_n; s_stop = stop_cnt; s_scl = scl_cyc;
    i2c_start();
    send_byte(8'hA0, ack);  check("t1_addr_ack", 32'(ack), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    send_byte(8'hA5, ack);  check("t1_ack_a5", 32'(ack), 32'd1);
    send_byte(8'h3C, ack);  check("t1_ack_3c", 32'(ack), 32'd1);
    i2c_stop();
    tick(10);
    check("t1_nbytes", 32'(log_n - base), 32'd2);
    check("t1_byte0", 32'(log_mem[6'(base)]), 32'h1A5);
    check("t1_byte1", 32'(log_mem[6'(base + 1)]), 32'h03C);
    check("t1_stop_pulse", 32'(stop_cnt - s_stop), 32'd1);
    check("t1_no_stretch", 32'(scl_cyc - s_scl), 32'd0);
    check("t1_busy_after", 32'(bus.busy), 32'd0);

    // Wrong address 0x51
    base = log_n; s_stop = stop_cnt; s_sda = sda_cyc; s_rxv = rxv_cyc; s_busy = busy_cyc;
    i2c_start();
    send_byte(8'hA2, ack);  check("t2_nack", 32'(ack), 32'd0);
    send_byte(8'h55, ack);
    i2c_stop();
    tick(10);
    check("t2_sda_idle", 32'(sda_cyc - s_sda), 32'd0);
    check("t2_no_valid", 32'(rxv_cyc - s_rxv), 32'd0);
    check("t2_no_busy", 32'(busy_cyc - s_busy), 32'd0);
    check("t2_no_stop", 32'(stop_cnt - s_stop), 32'd0);

    // Stretch: 0x11 left unconsumed, 0x22 stretched until rx_ready rises
    rdy = 1'b0;
    base = log_n;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h11, ack);  check("t3_ack_11", 32'(ack), 32'd1);
    check("t3_hold_11", 32'({bus.rx_valid, bus.rx_data}), 32'h111);
    send_bits(8'h22, 8);
    check("t3_stretch", 32'({bus.scl_oe, bus.sda_oe}), 32'b10);
    sda_m = 1'b1;
    tick(50);
    check("t3_still_held", 32'({bus.rx_valid, bus.rx_data, bus.scl_oe}), 32'h223);
    rdy = 1'b1;
    t_sda = -1; t_scl = -1; cap = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (t_sda < 0 && bus.sda_oe) begin
        t_sda = i;
        cap   = bus.rx_data;
      end
      if (t_scl < 0 && !bus.scl_oe) t_scl = i;
    end
    check("t3_sda_latency", 32'(t_sda), 32'd1);
    check("t3_data_22", 32'(cap), 32'h22);
    check("t3_tsu", 32'(t_scl - t_sda), 32'(TSU));
    scl_high();
    tick(Q);
    ack = ~bus.sda_in;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
    check("t3_ack_22", 32'(ack), 32'd1);
    i2c_stop();
    tick(10);
    check("t3_nbytes", 32'(log_n - base), 32'd2);
    check("t3_byte0", 32'(log_mem[6'(base)]), 32'h111);
    check("t3_byte1", 32'(log_mem[6'(base + 1)]), 32'h022);

    // Read request to 0x50 is NACKed, repeated START write then succeeds
    base = log_n;
    i2c_start();
    send_byte(8'hA1, ack);  check("t4_read_nack", 32'(ack), 32'd0);
    check("t4_not_busy", 32'(bus.busy), 32'd0);
    i2c_start();
    send_byte(8'hA0, ack);  check("t4_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h5A, ack);  check("t4_ack_5a", 32'(ack), 32'd1);
    i2c_stop();
    tick(10);
    check("t4_nbytes", 32'(log_n - base), 32'd1);
    check("t4_byte0", 32'(log_mem[6'(base)]), 32'h15A);

    // Repeated START during the 5th data bit discards the partial byte
    base = log_n;
    i2c_start();
    send_byte(8'hA0, ack);
    send_bits(8'hF0, 4);
    i2c_start();
    send_byte(8'hA0, ack);  check("t5_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h77, ack);  check("t5_ack_77", 32'(ack), 32'd1);
    i2c_stop();
    tick(10);
    check("t5_nbytes", 32'(log_n - base), 32'd1);
    check("t5_byte0", 32'(log_mem[6'(base)]), 32'h177);

    // Reset while stretching
    rdy = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h01, ack);
    send_bits(8'h02, 8);
    sda_m = 1'b1;
    check("t6_in_stretch", 32'({bus.scl_oe, bus.rx_valid, bus.busy}), 32'b111);
    rst = 1'b1;
    tick(1);
    check("t6_reset", 32'({bus.scl_oe, bus.sda_oe, bus.rx_valid, bus.busy}), 32'd0);
    rst = 1'b0;
    i2c_stop();
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
